// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falling edges, ACK check and watchdog.
// Optional build macro PS2_TX_RETRY_EN: one automatic resend of the latched
// byte on NACK or watchdog expiry before tx_error is reported.
// INHIBIT_CYCLES must be at least 2.
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_strb,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned WD_W    = 20;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 9;

  localparam logic [WD_W-1:0]  INH_PRE  = WD_W'(INHIBIT_CYCLES - 2);
  localparam logic [WD_W-1:0]  INH_END  = WD_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_END   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(8);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    STOP      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t               state_q, state_n;
  logic [FRAME_W-1:0]   shift_q, shift_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [WD_W-1:0]      wd_q, wd_n;
  logic                 clk_oe_q, clk_oe_n;
  logic                 data_oe_q, data_oe_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 error_q, error_n;
  logic                 fail;
`ifdef PS2_TX_RETRY_EN
  logic [FRAME_W-1:0]   frame_q, frame_n;
  logic                 retry_q, retry_n;
`endif

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fe;

  // Two-flop synchronizers for both bus lines plus one delay stage for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fe = clk_prev & ~clk_sync;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      frame_q   <= '0;
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      cnt_q     <= cnt_n;
      wd_q      <= wd_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      error_q   <= error_n;
`ifdef PS2_TX_RETRY_EN
      frame_q   <= frame_n;
      retry_q   <= retry_n;
`endif
    end
  end

  // Next-state and next-output logic; wd doubles as inhibit timer and watchdog
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    wd_n      = (state_q == IDLE) ? '0 : wd_q + WD_W'(1);
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    error_n   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    frame_n   = frame_q;
    retry_n   = retry_q;
`endif

    unique case (state_q)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        busy_n    = 1'b0;
        if (tx_strb) begin
          state_n  = INHIBIT;
          shift_n  = {~^tx_data, tx_data};
          cnt_n    = '0;
          wd_n     = '0;
          clk_oe_n = 1'b1;
          busy_n   = 1'b1;
`ifdef PS2_TX_RETRY_EN
          frame_n  = {~^tx_data, tx_data};
          retry_n  = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        if (wd_q == INH_PRE) data_oe_n = 1'b1;
        if (wd_q == INH_END) begin
          state_n   = REQ;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          wd_n      = '0;
        end
      end
      REQ: begin
        if (fe) begin
          data_oe_n = ~shift_q[0];
          shift_n   = {1'b0, shift_q[FRAME_W-1:1]};
          cnt_n     = cnt_q + CNT_W'(1);
          wd_n      = '0;
          if (cnt_q == LAST_BIT) state_n = STOP;
        end else if (wd_q == WD_END) begin
          fail = 1'b1;
        end
      end
      STOP: begin
        if (fe) begin
          data_oe_n = 1'b0;
          wd_n      = '0;
          state_n   = ACK;
        end else if (wd_q == WD_END) begin
          fail = 1'b1;
        end
      end
      ACK: begin
        if (fe) begin
          if (!data_sync) begin
            state_n = WAIT_IDLE;
            wd_n    = '0;
          end else begin
            fail = 1'b1;
          end
        end else if (wd_q == WD_END) begin
          fail = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          wd_n    = '0;
        end else if (wd_q == WD_END) begin
          fail = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // NACK or watchdog: release the bus and report, or resend once if enabled
    if (fail) begin
      state_n   = IDLE;
      wd_n      = '0;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      busy_n    = 1'b0;
      error_n   = 1'b1;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_n  = 1'b1;
        state_n  = INHIBIT;
        shift_n  = frame_q;
        cnt_n    = '0;
        clk_oe_n = 1'b1;
        busy_n   = 1'b1;
        error_n  = 1'b0;
      end
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-drain keyboard model.
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int TMO  = 2000;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strb = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

  // open-drain bus: either side may pull low
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #10 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_strb(tx_strb),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, busy_pulse_cnt = 0;
  int err_cyc = 0, fall_cyc = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  // pulse monitor: counts done/error pulses and rule violations
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_error) begin
      err_cnt = err_cnt + 1;
      if (!err_prev) err_cyc = cyc;
    end
    if (tx_done && tx_error) both_cnt = both_cnt + 1;
    if ((tx_done && done_prev) || (tx_error && err_prev)) long_cnt = long_cnt + 1;
    if ((tx_done || tx_error) && tx_busy) busy_pulse_cnt = busy_pulse_cnt + 1;
    done_prev = tx_done;
    err_prev  = tx_error;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_strb = 1'b1;
    @(negedge clk);
    tx_strb = 1'b0;
  endtask

  // count cycles with ps2_clk_oe high and the index where data_oe first rose
  task automatic wait_inhibit(output int hi, output int de);
    hi = 0;
    de = 0;
    for (int i = 0; i < INH + 100; i++) begin
      if (!ps2_clk_oe) break;
      hi++;
      if (ps2_data_oe && de == 0) de = hi;
      @(negedge clk);
    end
  endtask

  // keyboard model: nfe clock pulses, samples host data_oe late in each low phase
  task automatic run_device(input int nfe, input logic ack, input int strb_at,
                            output logic [9:0] oe);
    oe = '0;
    for (int i = 1; i <= nfe; i++) begin
      repeat (HALF - 2) @(negedge clk);
      if (i == 11) dev_data = ~ack;
      repeat (2) @(negedge clk);
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      if (i <= 10) oe[i-1] = ps2_data_oe;
      if (i == strb_at) begin
        tx_data = 8'h00;
        tx_strb = 1'b1;
        @(negedge clk);
        tx_strb = 1'b0;
      end
      dev_clk = 1'b1;
    end
    if (nfe == 11) begin
      repeat (3) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_events(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt + err_cnt >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); else n_pass++;
    n_checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else n_pass++;
    n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else n_pass++;
    n_checks++; if (tx_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", tx_error); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({ps2_clk_oe, tx_busy} !== 2'b00) $display("FAIL idle_quiet: got %b expected 00", {ps2_clk_oe, tx_busy}); else n_pass++;
  endtask

  task automatic test_send_ed;
    int hi, de, d0, e0;
    logic [9:0] oe;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    n_checks++; if ({tx_busy, ps2_clk_oe} !== 2'b11) $display("FAIL ed_accept: got %b expected 11", {tx_busy, ps2_clk_oe}); else n_pass++;
    wait_inhibit(hi, de);
    n_checks++; if (hi != INH) $display("FAIL ed_inhibit_len: got %0d expected %0d", hi, INH); else n_pass++;
    n_checks++; if (de != INH) $display("FAIL ed_start_cycle: got %0d expected %0d", de, INH); else n_pass++;
    n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) $display("FAIL ed_start_bit: got %b expected 01", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
    run_device(11, 1'b1, 0, oe);
    n_checks++; if (oe !== 10'h012) $display("FAIL ed_oe_bits: got %h expected 012", oe); else n_pass++;
    wait_events(d0 + e0 + 1, 200);
    n_checks++; if (done_cnt != d0 + 1) $display("FAIL ed_done: got %0d expected %0d", done_cnt - d0, 1); else n_pass++;
    n_checks++; if (err_cnt != e0) $display("FAIL ed_error: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) $display("FAIL ed_release: got %b expected 000", {tx_busy, ps2_clk_oe, ps2_data_oe}); else n_pass++;
  endtask

  task automatic test_send_f4;
    int hi, de, d0, e0;
    logic [9:0] oe;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    wait_inhibit(hi, de);
    n_checks++; if (hi != INH) $display("FAIL f4_inhibit_len: got %0d expected %0d", hi, INH); else n_pass++;
    run_device(11, 1'b1, 0, oe);
    n_checks++; if (oe !== 10'h10B) $display("FAIL f4_oe_bits: got %h expected 10b", oe); else n_pass++;
    wait_events(d0 + e0 + 1, 200);
    n_checks++; if ((done_cnt - d0) != 1 || err_cnt != e0) $display("FAIL f4_result: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0); else n_pass++;
  endtask

  task automatic test_nack;
    int hi, de, d0, e0;
    logic [9:0] oe;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    wait_inhibit(hi, de);
    run_device(11, 1'b0, 0, oe);
`ifdef PS2_TX_RETRY_EN
    for (int i = 0; i < 100; i++) begin
      if (ps2_clk_oe) break;
      @(negedge clk);
    end
    n_checks++; if ({ps2_clk_oe, tx_busy} !== 2'b11) $display("FAIL nack_retry_inhibit: got %b expected 11", {ps2_clk_oe, tx_busy}); else n_pass++;
    n_checks++; if (err_cnt != e0) $display("FAIL nack_retry_no_error: got %0d expected 0", err_cnt - e0); else n_pass++;
    wait_inhibit(hi, de);
    run_device(11, 1'b0, 0, oe);
    n_checks++; if (oe !== 10'h10B) $display("FAIL nack_retry_bits: got %h expected 10b", oe); else n_pass++;
`endif
    wait_events(d0 + e0 + 1, 200);
    n_checks++; if ((err_cnt - e0) != 1 || done_cnt != d0) $display("FAIL nack_result: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0); else n_pass++;
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) $display("FAIL nack_release: got %b expected 000", {tx_busy, ps2_clk_oe, ps2_data_oe}); else n_pass++;
  endtask

  task automatic test_timeout;
    int hi, de, d0, e0, delta;
    logic [9:0] oe;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h5A);
    wait_inhibit(hi, de);
    run_device(4, 1'b1, 0, oe);
    n_checks++; if (oe[3:0] !== 4'b0101) $display("FAIL tmo_first_bits: got %b expected 0101", oe[3:0]); else n_pass++;
    wait_events(d0 + e0 + 1, 2 * (INH + TMO) + 1000);
    n_checks++; if ((err_cnt - e0) != 1 || done_cnt != d0) $display("FAIL tmo_result: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0); else n_pass++;
`ifndef PS2_TX_RETRY_EN
    delta = err_cyc - fall_cyc;
    n_checks++; if (delta < TMO || delta > TMO + 4) $display("FAIL tmo_latency: got %0d expected %0d..%0d", delta, TMO, TMO + 4); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) $display("FAIL tmo_release: got %b expected 000", {tx_busy, ps2_clk_oe, ps2_data_oe}); else n_pass++;
  endtask

  task automatic test_strb_busy;
    int hi, de, d0, e0;
    logic [9:0] oe;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    wait_inhibit(hi, de);
    run_device(11, 1'b1, 4, oe);
    n_checks++; if (oe !== 10'h012) $display("FAIL strb_busy_bits: got %h expected 012", oe); else n_pass++;
    wait_events(d0 + e0 + 1, 200);
    n_checks++; if ((done_cnt - d0) != 1 || err_cnt != e0) $display("FAIL strb_busy_result: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if ({tx_busy, ps2_clk_oe} !== 2'b00) $display("FAIL strb_not_queued: got %b expected 00", {tx_busy, ps2_clk_oe}); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int hi, de, d0, e0;
    logic [9:0] oe;
    send_byte(8'h0F);
    wait_inhibit(hi, de);
    run_device(6, 1'b1, 0, oe);
    n_checks++; if (oe[5:0] !== 6'b110000) $display("FAIL rstmid_bits: got %b expected 110000", oe[5:0]); else n_pass++;
    n_checks++; if ({tx_busy, ps2_data_oe} !== 2'b11) $display("FAIL rstmid_pre: got %b expected 11", {tx_busy, ps2_data_oe}); else n_pass++;
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) $display("FAIL rstmid_release: got %b expected 000", {tx_busy, ps2_clk_oe, ps2_data_oe}); else n_pass++;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (done_cnt != d0 || err_cnt != e0) $display("FAIL rstmid_no_pulse: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0); else n_pass++;
  endtask

  task automatic test_pulse_rules;
    n_checks++; if (both_cnt != 0) $display("FAIL pulse_exclusive: got %0d expected 0", both_cnt); else n_pass++;
    n_checks++; if (long_cnt != 0) $display("FAIL pulse_width: got %0d expected 0", long_cnt); else n_pass++;
    n_checks++; if (busy_pulse_cnt != 0) $display("FAIL pulse_busy_drop: got %0d expected 0", busy_pulse_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_send_ed;
    test_send_f4;
    test_nack;
    test_timeout;
    test_strb_busy;
    test_reset_mid;
    test_pulse_rules;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
